lamp_card_responder: RTL and testbench
======================================

LAMP_CARD_RESPONDER -- requirements
Module: lamp_card_responder

Interface
REQ-001 Parameter BOARD_ID, default 4'd0: board address this responder answers to on BOARD_X.
REQ-002 Parameter ADC_SEED, default 8'h00: initial emulated ADC sample value.
REQ-003 Parameter ADC_STEP, default 8'h01: increment applied to the ADC sample after each ADC read.
REQ-004 clock  input  1: single system clock (27 MHz); all state changes on its rising edge.
REQ-005 reset_n  input  1: asynchronous, active-low reset.
REQ-006 BOARD_X  input  4: board select from the tester.
REQ-007 AddessPortPin  input  3: register address.
REQ-008 RdP  input  1: read strobe, active high.
REQ-009 WrP  input  1: write strobe, active high.
REQ-010 TestAddressP  input  1: test-address qualifier for reads, active high.
REQ-011 LampResetPin  input  1: card reset, active high.
REQ-012 data_in  input  8: data bus value as driven by the tester.
REQ-013 data_out  output  8: read data returned to the tester.
REQ-014 data_oe  output  1: high while the responder drives the data bus.
REQ-015 write_count  output  8: count of accepted writes, wraps at 8'hFF.
REQ-016 read_count  output  8: count of accepted reads, wraps at 8'hFF.
REQ-017 bus_error  output  1: sticky protocol-error flag.

Function
REQ-018 SHALL pass all bus inputs (BOARD_X, AddessPortPin, RdP, WrP, TestAddressP, LampResetPin, data_in) through a 2-flop synchroniser, and SHALL make all decisions on the second-stage (s2) values.
REQ-019 SHALL detect a strobe rising edge when s2=1 and the previous s2=0, and SHALL detect a falling edge when s2=0 and the previous s2=1.
REQ-020 SHALL be "selected" only when s2 BOARD_X equals BOARD_ID.
REQ-021 SHALL hold an 8x8 register file; address 7 reads return the ADC sample and do not return reg[7].
REQ-022 FSM states: IDLE, WRITE_COMMIT, WAIT_WR_LOW, READ_DRIVE.
REQ-023 IDLE -> WRITE_COMMIT on a WrP rise while selected with RdP s2=0; latches the address and data_in.
REQ-024 WRITE_COMMIT: writes reg[addr] <= data, increments write_count, goes to WAIT_WR_LOW; a write to address 7 updates reg[7] only.
REQ-025 WAIT_WR_LOW -> IDLE when WrP s2=0; exactly one write per strobe, however long WrP is held.
REQ-026 IDLE -> READ_DRIVE on a RdP rise while selected with WrP s2=0; on the same edge, loads data_out, sets data_oe=1 and increments read_count.
REQ-027 Read data: TestAddressP s2=1 gives {BOARD_ID,1'b0,addr}; else addr=7 gives the ADC sample and then adds ADC_STEP (mod 256); else reg[addr].
REQ-028 READ_DRIVE: holds data_out stable and data_oe=1 until the RdP fall; on the fall, clears data_oe and returns to IDLE.
REQ-029 Latency: a strobe rising at the input pin becomes visible (data_oe=1 or register updated) no later than the 4th rising clock edge after it.
REQ-030 Strobe rises while not selected SHALL be ignored: no state change, counters unchanged, data_oe stays 0.
REQ-031 RdP s2=1 and WrP s2=1 together in any state SHALL set bus_error=1, clear data_oe, return to IDLE, and cause neither a read nor a write.
REQ-032 bus_error SHALL clear only on reset_n.
REQ-033 LampResetPin s2=1 SHALL, on each clock: clear the register file to 8'h00, set the ADC sample to ADC_SEED, clear data_oe, force IDLE and ignore strobes; the counters are unaffected.
REQ-034 data_oe SHALL never be 1 outside READ_DRIVE.
REQ-035 Counters SHALL wrap from 8'hFF to 8'h00.

Reset
REQ-036 While reset_n=0, SHALL asynchronously set: data_out=8'h00, data_oe=0, write_count=0, read_count=0, bus_error=0, register file all 8'h00, ADC sample=ADC_SEED, FSM=IDLE, synchronisers=0.
REQ-037 A reset_n assertion during READ_DRIVE SHALL drop data_oe immediately, without waiting for a clock edge.
REQ-038 After reset_n deasserts, a strobe already high SHALL NOT be treated as a rising edge until it has been seen low.

Verification
REQ-039 BOARD_X=0, addr=3, data_in=8'hA5, WrP pulse of 5 cycles; then a RdP pulse at addr 3 -> data_out=8'hA5, data_oe=1 only during the strobe, write_count=1, read_count=1.
REQ-040 Three reads at addr 7 (ADC_SEED=8'h10, ADC_STEP=8'h01) -> data_out 8'h10, 8'h11, 8'h12.
REQ-041 BOARD_X=5 with a write then a read at addr 2 -> no update, data_oe stays 0, counters stay 0.
REQ-042 RdP and WrP high together -> bus_error=1 and persists; the next legal read of addr 0 returns 8'h00.
REQ-043 Write 8'h3C at addr 1, pulse LampResetPin, read addr 1 -> 8'h00; read with TestAddressP=1 at addr 6 -> 8'h06.
REQ-044 reset_n asserted mid READ_DRIVE -> data_oe=0 without a clock edge; RdP held high across the release -> no read until RdP toggles.

Source files
------------

// File: rtl/lamp_card_responder_if.sv
// Tester-side bus of the lamp card: board select, address, strobes and the
// shared data bus. The master is the tester and the slave is the responder card.
interface lamp_card_responder_if;
   // Strobe protocol: the master sets BOARD_X, AddessPortPin, TestAddressP and
   // data_in before it raises RdP or WrP, and holds them until it drops the
   // strobe. One rising edge is one transfer, however long the strobe stays high.
   // During a read, data_out is valid while data_oe=1, and data_oe drops after
   // RdP falls. RdP and WrP high together is a protocol error.
   logic [3:0] BOARD_X;
   logic [2:0] AddessPortPin;
   logic       RdP;
   logic       WrP;
   logic       TestAddressP;
   logic       LampResetPin;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;

   modport master (
      output BOARD_X, AddessPortPin, RdP, WrP, TestAddressP, LampResetPin, data_in,
      input  data_out, data_oe
   );

   modport slave (
      input  BOARD_X, AddessPortPin, RdP, WrP, TestAddressP, LampResetPin, data_in,
      output data_out, data_oe
   );
endinterface

// File: rtl/lamp_card_responder.sv
// Emulated lamp card: a synchronised strobe bus, an 8x8 register file, and an
// auto-incrementing ADC sample at address 7.
module lamp_card_responder #(
   parameter logic [3:0] BOARD_ID = 4'd0,
   parameter logic [7:0] ADC_SEED = 8'h00,
   parameter logic [7:0] ADC_STEP = 8'h01
) (
   input  logic                        clock,
   input  logic                        reset_n,
   lamp_card_responder_if.slave        bus,
   output logic [7:0]                  write_count,
   output logic [7:0]                  read_count,
   output logic                        bus_error,
   output logic [1:0]                  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_WRITE_COMMIT = 2'd1,
      S_WAIT_WR_LOW  = 2'd2,
      S_READ_DRIVE   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [18:0] w_raw;
   logic [18:0] r_s1;
   logic [18:0] r_s2;
   logic [1:0]  r_warm;
   logic        r_rd_prev;
   logic        r_wr_prev;

   logic [3:0]  w_board;
   logic [2:0]  w_addr;
   logic        w_rd;
   logic        w_wr;
   logic        w_test;
   logic        w_lamp;
   logic [7:0]  w_din;

   logic        w_sel;
   logic        w_rd_rise;
   logic        w_rd_fall;
   logic        w_wr_rise;
   logic        w_err;
   logic        w_start_write;
   logic        w_do_write;
   logic        w_do_read;
   logic        w_adc_read;
   logic [7:0]  w_rd_data;

   logic [7:0]  r_regs [0:7];
   logic [7:0]  r_adc;
   logic [2:0]  r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_data_out;
   logic [7:0]  r_write_count;
   logic [7:0]  r_read_count;
   logic        r_bus_error;

   assign w_raw = {bus.BOARD_X, bus.AddessPortPin, bus.RdP, bus.WrP,
                   bus.TestAddressP, bus.LampResetPin, bus.data_in};

   assign {w_board, w_addr, w_rd, w_wr, w_test, w_lamp, w_din} = r_s2;

   // The previous-strobe flops start high and stay high until the synchroniser
   // has filled, so a strobe already high at reset release has to go low first.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_warm    <= 2'b00;
         r_rd_prev <= 1'b1;
         r_wr_prev <= 1'b1;
      end else begin
         r_s1   <= w_raw;
         r_s2   <= r_s1;
         r_warm <= {r_warm[0], 1'b1};
         if (r_warm[1]) begin
            r_rd_prev <= w_rd;
            r_wr_prev <= w_wr;
         end
      end
   end

   assign w_sel      = (w_board == BOARD_ID);
   assign w_rd_rise  = w_rd & ~r_rd_prev;
   assign w_rd_fall  = ~w_rd & r_rd_prev;
   assign w_wr_rise  = w_wr & ~r_wr_prev;
   assign w_err      = w_rd & w_wr & ~w_lamp;
   assign w_adc_read = ~w_test & (w_addr == 3'd7);
   assign w_rd_data  = w_test ? {BOARD_ID, 1'b0, w_addr} :
                       (w_addr == 3'd7) ? r_adc : r_regs[w_addr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_start_write = 1'b0;
      w_do_write    = 1'b0;
      w_do_read     = 1'b0;
      if (w_lamp || w_err) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sel && w_wr_rise && !w_rd) begin
                  w_state_next  = S_WRITE_COMMIT;
                  w_start_write = 1'b1;
               end else if (w_sel && w_rd_rise && !w_wr) begin
                  w_state_next = S_READ_DRIVE;
                  w_do_read    = 1'b1;
               end
            end
            S_WRITE_COMMIT: begin
               w_state_next = S_WAIT_WR_LOW;
               w_do_write   = 1'b1;
            end
            S_WAIT_WR_LOW: begin
               if (!w_wr) w_state_next = S_IDLE;
            end
            S_READ_DRIVE: begin
               if (w_rd_fall) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
         r_adc         <= ADC_SEED;
         r_addr        <= 3'd0;
         r_wdata       <= 8'h00;
         r_data_out    <= 8'h00;
         r_write_count <= 8'h00;
         r_read_count  <= 8'h00;
         r_bus_error   <= 1'b0;
      end else begin
         if (w_err) r_bus_error <= 1'b1;
         if (w_lamp) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
            r_adc <= ADC_SEED;
         end else begin
            if (w_start_write) begin
               r_addr  <= w_addr;
               r_wdata <= w_din;
            end
            if (w_do_write) begin
               r_regs[r_addr] <= r_wdata;
               r_write_count  <= r_write_count + 8'd1;
            end
            if (w_do_read) begin
               r_data_out   <= w_rd_data;
               r_read_count <= r_read_count + 8'd1;
               if (w_adc_read) r_adc <= r_adc + ADC_STEP;
            end
         end
      end
   end

   // Output enable is decoded from the state so it can never outlive READ_DRIVE.
   assign bus.data_oe  = (r_state == S_READ_DRIVE);
   assign bus.data_out = r_data_out;
   assign write_count  = r_write_count;
   assign read_count   = r_read_count;
   assign bus_error    = r_bus_error;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_lamp_card_responder.sv
// Directed bench for lamp_card_responder: writes, reads, ADC stepping, board
// filtering, protocol error, card reset and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_lamp_card_responder;

   logic       clk;
   logic       reset_n;
   logic [7:0] write_count;
   logic [7:0] read_count;
   logic       bus_error;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_errors;

   lamp_card_responder_if bus ();

   lamp_card_responder #(
      .BOARD_ID (4'd0),
      .ADC_SEED (8'h10),
      .ADC_STEP (8'h01)
   ) dut (
      .clock       (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .write_count (write_count),
      .read_count  (read_count),
      .bus_error   (bus_error),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #18.5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [3:0] board, input logic [2:0] addr,
                            input logic [7:0] data, input int hold);
      bus.BOARD_X       = board;
      bus.AddessPortPin = addr;
      bus.data_in       = data;
      bus.TestAddressP  = 1'b0;
      bus.WrP           = 1'b1;
      wait_clks(hold);
      bus.WrP = 1'b0;
      wait_clks(5);
   endtask

   // Raises RdP, checks data_oe (and data_out when a drive is expected) while
   // the strobe is held, then checks data_oe has dropped after the fall.
   task automatic bus_read(input string tag, input logic [3:0] board, input logic [2:0] addr,
                           input logic test, input logic exp_oe, input logic [7:0] exp_data);
      bus.BOARD_X       = board;
      bus.AddessPortPin = addr;
      bus.TestAddressP  = test;
      bus.RdP           = 1'b1;
      wait_clks(5);
      check_eq($sformatf("%s_oe_during", tag), bus.data_oe, exp_oe);
      if (exp_oe) check_eq($sformatf("%s_data", tag), bus.data_out, exp_data);
      bus.RdP = 1'b0;
      wait_clks(5);
      check_eq($sformatf("%s_oe_after", tag), bus.data_oe, 1'b0);
      bus.TestAddressP = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      bus.BOARD_X       = 4'd0;
      bus.AddessPortPin = 3'd0;
      bus.RdP           = 1'b0;
      bus.WrP           = 1'b0;
      bus.TestAddressP  = 1'b0;
      bus.LampResetPin  = 1'b0;
      bus.data_in       = 8'h00;
      wait_clks(3);
      check_eq("rst_data_out", bus.data_out, 8'h00);
      check_eq("rst_data_oe", bus.data_oe, 1'b0);
      check_eq("rst_write_count", write_count, 8'h00);
      check_eq("rst_read_count", read_count, 8'h00);
      check_eq("rst_bus_error", bus_error, 1'b0);
      check_eq("rst_state", dbg_state, 2'd0);
      reset_n = 1'b1;
      wait_clks(3);

      // Basic write then read back, one write per long strobe.
      bus_write(4'd0, 3'd3, 8'hA5, 5);
      check_eq("wr1_count", write_count, 8'd1);
      check_eq("wr1_oe", bus.data_oe, 1'b0);
      bus_read("rd_a3", 4'd0, 3'd3, 1'b0, 1'b1, 8'hA5);
      check_eq("rd1_count", read_count, 8'd1);
      bus_write(4'd0, 3'd4, 8'h5A, 20);
      check_eq("wr_long_count", write_count, 8'd2);
      bus_read("rd_a4", 4'd0, 3'd4, 1'b0, 1'b1, 8'h5A);

      // ADC sample steps on every address-7 read; writing reg[7] leaves it alone.
      bus_read("adc0", 4'd0, 3'd7, 1'b0, 1'b1, 8'h10);
      bus_read("adc1", 4'd0, 3'd7, 1'b0, 1'b1, 8'h11);
      bus_read("adc2", 4'd0, 3'd7, 1'b0, 1'b1, 8'h12);
      check_eq("adc_read_count", read_count, 8'd5);
      bus_write(4'd0, 3'd7, 8'h77, 3);
      bus_read("adc3", 4'd0, 3'd7, 1'b0, 1'b1, 8'h13);
      check_eq("adc_wr_count", write_count, 8'd3);

      // Another board's traffic is ignored.
      bus_write(4'd5, 3'd2, 8'hEE, 5);
      bus_read("nosel", 4'd5, 3'd2, 1'b0, 1'b0, 8'h00);
      check_eq("nosel_wcount", write_count, 8'd3);
      check_eq("nosel_rcount", read_count, 8'd6);
      bus_read("nosel_a2", 4'd0, 3'd2, 1'b0, 1'b1, 8'h00);

      // Both strobes together: sticky error, no transfer.
      bus.BOARD_X       = 4'd0;
      bus.AddessPortPin = 3'd0;
      bus.RdP           = 1'b1;
      bus.WrP           = 1'b1;
      wait_clks(5);
      check_eq("err_flag", bus_error, 1'b1);
      check_eq("err_oe", bus.data_oe, 1'b0);
      bus.RdP = 1'b0;
      bus.WrP = 1'b0;
      wait_clks(5);
      check_eq("err_wcount", write_count, 8'd3);
      check_eq("err_rcount", read_count, 8'd7);
      bus_read("err_a0", 4'd0, 3'd0, 1'b0, 1'b1, 8'h00);
      check_eq("err_sticky", bus_error, 1'b1);

      // Card reset clears registers and ADC but not the counters.
      bus_write(4'd0, 3'd1, 8'h3C, 4);
      bus_read("pre_lamp_a1", 4'd0, 3'd1, 1'b0, 1'b1, 8'h3C);
      bus.LampResetPin = 1'b1;
      wait_clks(3);
      bus.LampResetPin = 1'b0;
      wait_clks(4);
      check_eq("lamp_wcount", write_count, 8'd4);
      check_eq("lamp_rcount", read_count, 8'd9);
      bus_read("lamp_a1", 4'd0, 3'd1, 1'b0, 1'b1, 8'h00);
      bus_read("lamp_adc", 4'd0, 3'd7, 1'b0, 1'b1, 8'h10);
      bus_read("test_a6", 4'd0, 3'd6, 1'b1, 1'b1, 8'h06);
      check_eq("test_rcount", read_count, 8'd12);

      // Asynchronous reset mid-read, strobe held across release.
      bus.BOARD_X       = 4'd0;
      bus.AddessPortPin = 3'd3;
      bus.RdP           = 1'b1;
      wait_clks(5);
      check_eq("arst_pre_oe", bus.data_oe, 1'b1);
      #5 reset_n = 1'b0;
      #1;
      check_eq("arst_oe_now", bus.data_oe, 1'b0);
      check_eq("arst_data_now", bus.data_out, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      wait_clks(8);
      check_eq("arst_held_oe", bus.data_oe, 1'b0);
      check_eq("arst_held_rcount", read_count, 8'd0);
      bus.RdP = 1'b0;
      wait_clks(4);
      bus.RdP = 1'b1;
      wait_clks(5);
      check_eq("arst_retry_oe", bus.data_oe, 1'b1);
      check_eq("arst_retry_rcount", read_count, 8'd1);
      check_eq("arst_retry_data", bus.data_out, 8'h00);
      check_eq("arst_error_clear", bus_error, 1'b0);
      bus.RdP = 1'b0;
      wait_clks(5);
      check_eq("arst_retry_oe_after", bus.data_oe, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
